state_snapshot_streamer: RTL and testbench

- Debug-side reader of CPU architectural state. On a snapshot request it stalls the pipeline, then reads a header, all 32 registers and the low data-memory words through read ports.
- It emits them as a word stream with a valid/ready handshake.
- It is the hardware counterpart of the per-cycle software state dump. It sits beside the CPU on the register-file and data-memory debug read ports.

---
 rtl/state_snapshot_streamer.sv | 215 +++++++++++++++++++++
 tb/tb_state_snapshot_streamer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_snapshot_streamer.sv
// ============================================================================
// state_snapshot_streamer
// ----------------------------------------------------------------------------
// Debug-side reader of CPU architectural state. A snapshot request freezes
// the pipeline (stall_o), then the block streams a 3-word header (captured
// cycle count, PC, predict/flush flags), every register x0..x(NUM_REGS-1) and
// the low NUM_MEM_WORDS data-memory words over a valid/ready stream.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   snap_i               snapshot request, sampled every rising edge
//   pc_i                 current PC (captured into header word 1)
//   predict_i, flush_i   predictor / IF-ID flush flags (header word 2)
//   reg_addr_o           register-file debug read address
//   reg_data_i           register read data, combinational from reg_addr_o
//   mem_addr_o           data-memory debug byte address (word aligned)
//   mem_data_i           memory read data, combinational from mem_addr_o
//   stall_o              holds the CPU pipeline while a snapshot runs
//   busy_o               a snapshot is in progress
//   out_valid_o          stream word valid
//   out_ready_i          sink accepts the stream word
//   out_data_o           stream word
//   out_tag_o            word kind: 0 header, 1 register, 2 memory
//   out_last_o           final word of a snapshot
//   overrun_o            sticky: a snapshot request arrived while busy
// ============================================================================
module state_snapshot_streamer #(
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8,
    parameter int DATA_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              snap_i,
    input  logic [31:0]       pc_i,
    input  logic              predict_i,
    input  logic              flush_i,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [31:0]       mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        out_tag_o,
    output logic              out_last_o,
    output logic              overrun_o
);

    localparam int HDR_WORDS   = 3;
    localparam int TOTAL_WORDS = HDR_WORDS + NUM_REGS + NUM_MEM_WORDS;
    localparam int CNT_W       = $clog2(TOTAL_WORDS + 1);

    localparam logic [1:0] TAG_HDR = 2'd0;
    localparam logic [1:0] TAG_REG = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_REG,
        S_MEM
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_cycle;
    logic [DATA_W-1:0]   r_hdrCycle;
    logic [31:0]         r_hdrPc;
    logic                r_hdrPred;
    logic                r_hdrFlush;
    // r_loadIdx counts words loaded into the output register, r_acceptIdx
    // counts words handed to the sink; loading runs one word ahead of
    // acceptance, so the state (driven by acceptance) lags the read ports.
    logic [CNT_W-1:0]    r_loadIdx;
    logic [CNT_W-1:0]    r_acceptIdx;
    logic [4:0]          r_regAddr;
    logic [31:0]         r_memAddr;
    logic                r_busy;
    logic                r_outValid;
    logic [DATA_W-1:0]   r_outData;
    logic [1:0]          r_outTag;
    logic                r_outLast;
    logic                r_overrun;

    logic [DATA_W-1:0]   w_wordData;
    logic [1:0]          w_wordTag;
    logic                w_wordLast;
    logic                w_wordIsReg;
    logic                w_wordIsMem;
    logic                w_load;
    logic                w_accept;

    assign w_accept = r_outValid && out_ready_i;
    assign w_load   = (r_state != S_IDLE)
                   && (r_loadIdx < CNT_W'(TOTAL_WORDS))
                   && (!r_outValid || out_ready_i);

    // Select the next word to load from its position in the stream. Register
    // and memory words come straight off the combinational debug read ports,
    // which are addressed by r_regAddr / r_memAddr.
    always_comb begin
        w_wordData  = '0;
        w_wordTag   = TAG_HDR;
        w_wordLast  = 1'b0;
        w_wordIsReg = 1'b0;
        w_wordIsMem = 1'b0;
        if (r_loadIdx == CNT_W'(0)) begin
            w_wordData = r_hdrCycle;
        end else if (r_loadIdx == CNT_W'(1)) begin
            w_wordData = DATA_W'(r_hdrPc);
        end else if (r_loadIdx == CNT_W'(2)) begin
            w_wordData = {{(DATA_W-2){1'b0}}, r_hdrPred, r_hdrFlush};
        end else if (r_loadIdx < CNT_W'(HDR_WORDS + NUM_REGS)) begin
            w_wordData  = reg_data_i;
            w_wordTag   = TAG_REG;
            w_wordIsReg = 1'b1;
        end else begin
            w_wordData  = mem_data_i;
            w_wordTag   = TAG_MEM;
            w_wordIsMem = 1'b1;
            w_wordLast  = (r_loadIdx == CNT_W'(TOTAL_WORDS - 1));
        end
    end

    // Snapshot FSM, free-running cycle counter and registered stream outputs.
    // The header is captured with the pre-increment counter value at the edge
    // that starts the snapshot. A request seen in any non-idle state, including
    // the edge that accepts the last word, only raises the sticky overrun flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cycle     <= '0;
            r_hdrCycle  <= '0;
            r_hdrPc     <= '0;
            r_hdrPred   <= 1'b0;
            r_hdrFlush  <= 1'b0;
            r_loadIdx   <= '0;
            r_acceptIdx <= '0;
            r_regAddr   <= '0;
            r_memAddr   <= '0;
            r_busy      <= 1'b0;
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outTag    <= '0;
            r_outLast   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cycle <= r_cycle + DATA_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (snap_i) begin
                        r_state     <= S_HDR;
                        r_hdrCycle  <= r_cycle;
                        r_hdrPc     <= pc_i;
                        r_hdrPred   <= predict_i;
                        r_hdrFlush  <= flush_i;
                        r_loadIdx   <= '0;
                        r_acceptIdx <= '0;
                        r_regAddr   <= '0;
                        r_memAddr   <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                default: begin
                    if (snap_i) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_load) begin
                        r_outValid <= 1'b1;
                        r_outData  <= w_wordData;
                        r_outTag   <= w_wordTag;
                        r_outLast  <= w_wordLast;
                        r_loadIdx  <= r_loadIdx + CNT_W'(1);
                        if (w_wordIsReg) begin
                            r_regAddr <= r_regAddr + 5'd1;
                        end
                        if (w_wordIsMem) begin
                            r_memAddr <= r_memAddr + 32'd4;
                        end
                    end else if (w_accept) begin
                        r_outValid <= 1'b0;
                    end
                    if (w_accept) begin
                        r_acceptIdx <= r_acceptIdx + CNT_W'(1);
                        if (r_acceptIdx == CNT_W'(HDR_WORDS - 1)) begin
                            r_state <= S_REG;
                        end else if (r_acceptIdx == CNT_W'(HDR_WORDS + NUM_REGS - 1)) begin
                            r_state <= S_MEM;
                        end else if (r_acceptIdx == CNT_W'(TOTAL_WORDS - 1)) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                            r_regAddr  <= '0;
                            r_memAddr  <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign reg_addr_o  = r_regAddr;
    assign mem_addr_o  = r_memAddr;
    assign busy_o      = r_busy;
    assign stall_o     = r_busy;
    assign out_valid_o = r_outValid;
    assign out_data_o  = r_outData;
    assign out_tag_o   = r_outTag;
    assign out_last_o  = r_outLast;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_state_snapshot_streamer.sv
// ============================================================================
// tb_state_snapshot_streamer
// ----------------------------------------------------------------------------
// Self-checking bench. Register file and data memory are arrays in the bench
// answering the debug read ports combinationally. The expected stream is the
// header followed by regs[0..31] and mem[0..7], built directly from those
// arrays; the cycle counter is modelled as edges since the last reset edge.
// ============================================================================
module tb_state_snapshot_streamer;

    localparam int NWORDS = 43;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        snap_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        predict_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        stall_o;
    logic        busy_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic [1:0]  out_tag_o;
    logic        out_last_o;
    logic        overrun_o;

    logic [31:0] regs [32];
    logic [31:0] mem  [16];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tbCycle = '0;
    logic [31:0] expH0 = '0;

    logic [31:0] gotData [$];
    logic [1:0]  gotTag  [$];
    logic        gotLast [$];

    state_snapshot_streamer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .snap_i      (snap_i),
        .pc_i        (pc_i),
        .predict_i   (predict_i),
        .flush_i     (flush_i),
        .reg_addr_o  (reg_addr_o),
        .reg_data_i  (reg_data_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_tag_o   (out_tag_o),
        .out_last_o  (out_last_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational debug read ports backed by the bench's state arrays.
    assign reg_data_i = regs[reg_addr_o];
    assign mem_data_i = (mem_addr_o < 32'd64) ? mem[mem_addr_o[5:2]] : 32'hDEADBEEF;

    // One clock: advance the cycle-count model at the edge, return at negedge.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i) tbCycle = '0;
        else       tbCycle = tbCycle + 32'd1;
        @(negedge clk_i);
    endtask

    // Expected word i of a snapshot: header, registers, then memory words.
    function automatic logic [31:0] expWord(input int i);
        if (i == 0)      return expH0;
        else if (i == 1) return pc_i;
        else if (i == 2) return {30'b0, predict_i, flush_i};
        else if (i < 35) return regs[i-3];
        else             return mem[i-35];
    endfunction

    function automatic logic [1:0] expTag(input int i);
        if (i < 3)       return 2'd0;
        else if (i < 35) return 2'd1;
        else             return 2'd2;
    endfunction

    task automatic randomize_state();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        pc_i      = $urandom & 32'hFFFF_FFFC;
        predict_i = 1'($urandom_range(0, 1));
        flush_i   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        out_ready_i = 1'b0;
        snap_i = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    // Drives one snapshot and records every accepted word. readyMode:
    // 0 always ready, 1 pattern 1,0,0,1 during register words, 2 random.
    // snapAgainAt / resetAt (>=0) fire when that many words have been taken.
    task automatic run_snapshot(input int readyMode, input int snapAgainAt,
                                input int resetAt, output bit sawLast,
                                output int nEdges);
        int          pat [4] = '{1, 0, 0, 1};
        int          phase = 0;
        bit          done = 0;
        bit          aborted = 0;
        bit          prevHeld = 0;
        logic [31:0] holdData = '0;
        logic [1:0]  holdTag = '0;
        logic        holdLast = 0;
        logic [4:0]  holdReg = '0;
        logic [31:0] holdMem = '0;
        gotData.delete();
        gotTag.delete();
        gotLast.delete();
        nEdges = 0;
        snap_i = 1'b1;
        expH0 = tbCycle;
        tick();
        snap_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b1 || stall_o !== 1'b1)
            begin errors++; $display("[TB] FAIL snap_latency: valid=%b busy=%b stall=%b required 0/1/1", out_valid_o, busy_o, stall_o); end
        for (int c = 0; c < 400 && !done && !aborted; c++) begin
            if (prevHeld) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== holdData || out_tag_o !== holdTag ||
                    out_last_o !== holdLast || reg_addr_o !== holdReg || mem_addr_o !== holdMem)
                    begin errors++; $display("[TB] FAIL hold: data=%h tag=%0d reg=%0d mem=%h required data=%h tag=%0d reg=%0d mem=%h", out_data_o, out_tag_o, reg_addr_o, mem_addr_o, holdData, holdTag, holdReg, holdMem); end
            end
            checks++;
            if (stall_o !== busy_o)
                begin errors++; $display("[TB] FAIL stall_eq_busy: stall=%b required %b", stall_o, busy_o); end
            if (resetAt >= 0 && gotData.size() == resetAt) begin
                out_ready_i = 1'b0;
                do_reset();
                checks++;
                if (out_valid_o !== 0 || busy_o !== 0 || stall_o !== 0 || out_data_o !== 0 ||
                    out_tag_o !== 0 || out_last_o !== 0 || overrun_o !== 0 ||
                    reg_addr_o !== 0 || mem_addr_o !== 0)
                    begin errors++; $display("[TB] FAIL mid_reset_zero: valid=%b busy=%b stall=%b data=%h last=%b required all 0", out_valid_o, busy_o, stall_o, out_data_o, out_last_o); end
                aborted = 1;
            end else begin
                case (readyMode)
                    0: out_ready_i = 1'b1;
                    1: begin
                        if (out_valid_o && out_tag_o == 2'd1) begin
                            out_ready_i = pat[phase % 4] != 0;
                            phase++;
                        end else begin
                            out_ready_i = 1'b1;
                        end
                    end
                    default: out_ready_i = 1'($urandom_range(0, 1));
                endcase
                snap_i = (snapAgainAt >= 0 && gotData.size() == snapAgainAt);
                if (out_valid_o && out_ready_i) begin
                    gotData.push_back(out_data_o);
                    gotTag.push_back(out_tag_o);
                    gotLast.push_back(out_last_o);
                    if (out_last_o) done = 1;
                end
                prevHeld = out_valid_o && !out_ready_i;
                holdData = out_data_o;
                holdTag  = out_tag_o;
                holdLast = out_last_o;
                holdReg  = reg_addr_o;
                holdMem  = mem_addr_o;
                tick();
                nEdges++;
            end
        end
        snap_i = 1'b0;
        out_ready_i = 1'b0;
        sawLast = done;
        if (!done && !aborted) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: words=%0d required %0d", gotData.size(), NWORDS);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid_o !== 0 || busy_o !== 0 || stall_o !== 0 || out_data_o !== 0 ||
            out_tag_o !== 0 || out_last_o !== 0 || overrun_o !== 0)
            begin errors++; $display("[TB] FAIL reset_outputs: valid=%b busy=%b stall=%b data=%h tag=%0d last=%b ovr=%b required all 0", out_valid_o, busy_o, stall_o, out_data_o, out_tag_o, out_last_o, overrun_o); end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (reg_addr_o !== 5'd0 || mem_addr_o !== 32'd0 || busy_o !== 0 || out_valid_o !== 0)
            begin errors++; $display("[TB] FAIL idle_outputs: reg=%0d mem=%h busy=%b valid=%b required 0", reg_addr_o, mem_addr_o, busy_o, out_valid_o); end
    endtask

    task automatic test_basic_stream();
        bit sawLast;
        int nEdges;
        randomize_state();
        regs[24] = 32'hFFFF_FFE8;
        regs[28] = 32'd56;
        mem[0]   = 32'd5;
        mem[1]   = 32'd29;
        pc_i = 32'd8;
        predict_i = 1'b1;
        flush_i = 1'b0;
        run_snapshot(0, -1, -1, sawLast, nEdges);
        checks++;
        if (gotData.size() != NWORDS)
            begin errors++; $display("[TB] FAIL basic_count: got %0d required %0d", gotData.size(), NWORDS); end
        checks++;
        if (nEdges != 44)
            begin errors++; $display("[TB] FAIL basic_latency: last handshake after %0d edges required 44", nEdges); end
        checks++;
        if (busy_o !== 0 || stall_o !== 0 || out_valid_o !== 0)
            begin errors++; $display("[TB] FAIL basic_end: busy=%b stall=%b valid=%b required 0", busy_o, stall_o, out_valid_o); end
        for (int i = 0; i < gotData.size() && i < NWORDS; i++) begin
            checks++;
            if (gotData[i] !== expWord(i) || gotTag[i] !== expTag(i) || gotLast[i] !== (i == NWORDS - 1))
                begin errors++; $display("[TB] FAIL basic_word%0d: data=%h tag=%0d last=%b required %h %0d %b", i, gotData[i], gotTag[i], gotLast[i], expWord(i), expTag(i), i == NWORDS - 1); end
        end
    endtask

    task automatic test_backpressure(input int mode);
        bit sawLast;
        int nEdges;
        randomize_state();
        run_snapshot(mode, -1, -1, sawLast, nEdges);
        checks++;
        if (gotData.size() != NWORDS || !sawLast)
            begin errors++; $display("[TB] FAIL bp%0d_count: got %0d last=%b required %0d 1", mode, gotData.size(), sawLast, NWORDS); end
        for (int i = 0; i < gotData.size() && i < NWORDS; i++) begin
            checks++;
            if (gotData[i] !== expWord(i) || gotTag[i] !== expTag(i) || gotLast[i] !== (i == NWORDS - 1))
                begin errors++; $display("[TB] FAIL bp%0d_word%0d: data=%h tag=%0d got, required %h %0d", mode, i, gotData[i], gotTag[i], expWord(i), expTag(i)); end
        end
    endtask

    task automatic test_overrun();
        bit sawLast;
        int nEdges;
        randomize_state();
        run_snapshot(0, 10, -1, sawLast, nEdges);
        checks++;
        if (overrun_o !== 1'b1)
            begin errors++; $display("[TB] FAIL overrun_set: got %b required 1", overrun_o); end
        checks++;
        if (gotData.size() != NWORDS || nEdges != 44)
            begin errors++; $display("[TB] FAIL overrun_stream: words=%0d edges=%0d required %0d 44", gotData.size(), nEdges, NWORDS); end
        for (int i = 0; i < gotData.size() && i < NWORDS; i++) begin
            checks++;
            if (gotData[i] !== expWord(i) || gotTag[i] !== expTag(i))
                begin errors++; $display("[TB] FAIL overrun_word%0d: data=%h required %h", i, gotData[i], expWord(i)); end
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (overrun_o !== 1'b1 || busy_o !== 1'b0)
            begin errors++; $display("[TB] FAIL overrun_sticky: ovr=%b busy=%b required 1 0", overrun_o, busy_o); end
    endtask

    task automatic test_mid_reset();
        bit sawLast;
        int nEdges;
        randomize_state();
        run_snapshot(0, -1, 20, sawLast, nEdges);
        checks++;
        if (sawLast || gotData.size() != 20)
            begin errors++; $display("[TB] FAIL mid_reset_abort: last=%b words=%0d required 0 20", sawLast, gotData.size()); end
        run_snapshot(0, -1, -1, sawLast, nEdges);
        checks++;
        if (gotData.size() != NWORDS || gotData[0] !== expH0 || gotTag[0] !== 2'd0)
            begin errors++; $display("[TB] FAIL restart: words=%0d h0=%h required %0d %h", gotData.size(), gotData.size() > 0 ? gotData[0] : 32'hX, NWORDS, expH0); end
    endtask

    task automatic test_last_edge_snap();
        bit sawLast;
        int nEdges;
        do_reset();
        randomize_state();
        run_snapshot(0, NWORDS - 1, -1, sawLast, nEdges);
        checks++;
        if (overrun_o !== 1'b1)
            begin errors++; $display("[TB] FAIL last_edge_overrun: got %b required 1", overrun_o); end
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0)
            begin errors++; $display("[TB] FAIL last_edge_nostart: busy=%b valid=%b required 0 0", busy_o, out_valid_o); end
    endtask

    task automatic test_counter_wrap();
        bit sawLast;
        int nEdges;
        do_reset();
        force dut.r_cycle = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle;
        tbCycle = 32'hFFFF_FFFE;
        tick();
        tick();
        randomize_state();
        run_snapshot(0, -1, -1, sawLast, nEdges);
        checks++;
        if (gotData.size() == 0 || gotData[0] !== expH0)
            begin errors++; $display("[TB] FAIL counter_wrap: h0=%h required %h", gotData.size() > 0 ? gotData[0] : 32'hX, expH0); end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_basic_stream();
        test_backpressure(1);
        test_backpressure(2);
        test_overrun();
        test_mid_reset();
        test_last_edge_snap();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
